// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_issuer
// Purpose  : Issue stage for a combinational ALU. Commands {a, b, sel} arrive
//            over a valid/ready handshake into a small FIFO. A three-state FSM
//            pops one command at a time, drives the ALU inputs from registers,
//            waits ALU_LAT cycles, then captures alu_out. The captured result
//            and its opcode are offered downstream over valid/ready.
// Ports    : clk, rst_n (async, active low)
//            cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_sel : command input
//            alu_a/alu_b/alu_sel (out), alu_out (in)  : ALU interface
//            res_valid/res_ready/res_data/res_sel     : result output
//            busy : FSM not idle or commands still queued
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_issuer #(
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 3,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [SEL_W-1:0]  cmd_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [SEL_W-1:0]  res_sel,
    output logic              busy
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_cnt_w  = $clog2(DEPTH + 1);
    localparam int c_lat_w  = $clog2(ALU_LAT + 1);
    localparam int c_ent_w  = 2 * DATA_W + SEL_W;

    localparam logic [c_cnt_w-1:0]  c_full     = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_addr_w-1:0] c_addr_one = c_addr_w'(1);
    localparam logic [c_lat_w-1:0]  c_lat      = c_lat_w'(ALU_LAT);
    localparam logic [c_lat_w-1:0]  c_lat_one  = c_lat_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    logic [c_ent_w-1:0]  r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wptr, r_rptr;
    logic [c_cnt_w-1:0]  r_count;
    logic [c_lat_w-1:0]  r_wait;
    logic [DATA_W-1:0]   r_alu_a, r_alu_b, r_res_data;
    logic [SEL_W-1:0]    r_alu_sel, r_res_sel;
    logic                r_res_valid;

    logic w_empty, w_full, w_push, w_pop, w_capture;
    logic [c_ent_w-1:0] w_head;

    // Flags come from the registered count only, so an entry written on one
    // edge cannot be popped until the next, and a pop does not free a slot
    // for a push in the same cycle.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_full);
    assign w_push  = cmd_valid && !w_full;
    assign w_head  = r_mem[r_rptr];

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Counter reaches zero on this edge: alu_out has settled.
                if (r_wait == c_lat_one) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Command storage (payload needs no reset; pointers/count guard it)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {cmd_a, cmd_b, cmd_sel};
        end
    end

    // ------------------------------------------------------------------------
    // Pointers, occupancy, ALU drive, wait counter and result capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_wait      <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_sel   <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_addr_one;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase

            // ALU operands persist after use; only a pop replaces them.
            if (w_pop) begin
                r_rptr                           <= r_rptr + c_addr_one;
                {r_alu_a, r_alu_b, r_alu_sel}    <= w_head;
                r_wait                           <= c_lat;
            end else if (r_state == ST_WAIT) begin
                r_wait <= r_wait - c_lat_one;
            end

            if (w_capture) begin
                r_res_valid <= 1'b1;
                r_res_data  <= alu_out;
                r_res_sel   <= r_alu_sel;
            end else if ((r_state == ST_HOLD) && res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign cmd_ready = !w_full;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_sel   = r_res_sel;
    assign busy      = (r_state != ST_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_issuer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_alu_cmd_issuer
// Purpose  : Self-checking bench for alu_cmd_issuer. A behavioural ALU drives
//            alu_out; a queue-based scoreboard predicts every result from the
//            accepted commands. Directed sequences cover reset, latency,
//            back-to-back issue, backpressure, full-with-pop and reset
//            mid-operation, followed by a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_issuer;

    localparam int DATA_W  = 32;
    localparam int SEL_W   = 3;
    localparam int DEPTH   = 4;
    localparam int ALU_LAT = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a = '0;
    logic [DATA_W-1:0] cmd_b = '0;
    logic [SEL_W-1:0]  cmd_sel = '0;
    logic [DATA_W-1:0] alu_a, alu_b, alu_out;
    logic [SEL_W-1:0]  alu_sel;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [DATA_W-1:0] res_data;
    logic [SEL_W-1:0]  res_sel;
    logic              busy;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    logic [DATA_W+SEL_W-1:0] exp_q [$];
    logic [DATA_W-1:0]       res_log [$];
    int                      res_cyc [$];

    logic              hold_chk = 1'b0;
    logic [DATA_W-1:0] hold_data = '0;
    logic [SEL_W-1:0]  hold_sel = '0;

    alu_cmd_issuer #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W),
        .DEPTH  (DEPTH),
        .ALU_LAT(ALU_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_a    (cmd_a),
        .cmd_b    (cmd_b),
        .cmd_sel  (cmd_sel),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_sel  (alu_sel),
        .alu_out  (alu_out),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_sel  (res_sel),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 32-bit ALU: NOT, OR, AND, NEG, ADD, SUB, MUL, DIV.
    function automatic logic [DATA_W-1:0] alu_ref(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic [SEL_W-1:0]  s);
        case (s)
            3'd0:    return ~a;
            3'd1:    return a | b;
            3'd2:    return a & b;
            3'd3:    return -a;
            3'd4:    return a + b;
            3'd5:    return a - b;
            3'd6:    return a * b;
            default: return (b == '0) ? '1 : a / b;
        endcase
    endfunction

    assign alu_out = alu_ref(alu_a, alu_b, alu_sel);

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard / monitor: handshakes sampled mid-cycle take effect on the
    // following rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                check_eq("hold_valid", 64'(res_valid), 64'(1));
                check_eq("hold_data", 64'(res_data), 64'(hold_data));
                check_eq("hold_sel", 64'(res_sel), 64'(hold_sel));
            end
            hold_chk  = res_valid && !res_ready;
            hold_data = res_data;
            hold_sel  = res_sel;

            if (res_valid && res_ready) begin
                res_log.push_back(res_data);
                res_cyc.push_back(cyc);
                check_eq("res_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    logic [DATA_W+SEL_W-1:0] e;
                    e = exp_q.pop_front();
                    check_eq("res_data", 64'(res_data), 64'(e[DATA_W-1:0]));
                    check_eq("res_sel", 64'(res_sel), 64'(e[DATA_W+SEL_W-1:DATA_W]));
                end
            end

            if (cmd_valid && cmd_ready) begin
                exp_q.push_back({cmd_sel, alu_ref(cmd_a, cmd_b, cmd_sel)});
            end
        end
    end

    // Entered and left at posedge+1.
    task automatic push_cmd(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                            input logic [SEL_W-1:0] s);
        logic acc;
        int   g;
        acc = 1'b0;
        g   = 0;
        cmd_valid = 1'b1;
        cmd_a = a;
        cmd_b = b;
        cmd_sel = s;
        while (!acc && g < 100) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
            g++;
        end
        cmd_valid = 1'b0;
        check_eq("push_accepted", 64'(acc), 64'(1));
    endtask

    task automatic wait_results(input int n, input string tag);
        int g;
        g = 0;
        while (res_log.size() < n && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        check_eq(tag, 64'(res_log.size()), 64'(n));
    endtask

    logic [DATA_W-1:0] t3_exp [8] = '{32'hFFFF_FFFC, 32'h7, 32'h1, 32'hFFFF_FFFD,
                                      32'h8, 32'hFFFF_FFFE, 32'hF, 32'h0};

    initial begin
        int base;
        int i;
        int g;
        int seen;
        logic saw_nr;
        logic acc;
        logic [DATA_W-1:0] ra, rb, e0;
        logic [SEL_W-1:0]  rs;

        // ---------------- 1: reset then idle ----------------
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_res_valid", 64'(res_valid), 64'(0));
        check_eq("rst_res_data", 64'(res_data), 64'(0));
        check_eq("rst_res_sel", 64'(res_sel), 64'(0));
        check_eq("rst_alu", 64'({alu_a, alu_sel}), 64'(0));
        check_eq("rst_alu_b", 64'(alu_b), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_busy", 64'(busy), 64'(0));
        check_eq("idle_cmd_ready", 64'(cmd_ready), 64'(1));

        // ---------------- 2: single command latency ----------------
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_a = 32'd3;
        cmd_b = 32'd5;
        cmd_sel = 3'b100;
        @(negedge clk);
        check_eq("t2_ready", 64'(cmd_ready), 64'(1));
        @(posedge clk);               // edge N
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("t2_n_valid", 64'(res_valid), 64'(0));
        check_eq("t2_n_busy", 64'(busy), 64'(1));
        @(posedge clk);               // edge N+1
        @(negedge clk);
        check_eq("t2_alu_a", 64'(alu_a), 64'(3));
        check_eq("t2_alu_b", 64'(alu_b), 64'(5));
        check_eq("t2_alu_sel", 64'(alu_sel), 64'(4));
        check_eq("t2_n1_valid", 64'(res_valid), 64'(0));
        @(posedge clk);               // edge N+2
        @(negedge clk);
        check_eq("t2_n2_valid", 64'(res_valid), 64'(1));
        check_eq("t2_data", 64'(res_data), 64'(32'h8));
        check_eq("t2_sel", 64'(res_sel), 64'(3'b100));
        repeat (3) @(posedge clk);
        #1;
        check_eq("t2_idle", 64'(busy), 64'(0));

        // ---------------- 3: all opcodes back-to-back ----------------
        base   = res_log.size();
        saw_nr = 1'b0;
        i      = 0;
        g      = 0;
        cmd_valid = 1'b1;
        cmd_a = 32'd3;
        cmd_b = 32'd5;
        cmd_sel = 3'd0;
        while (i < 8 && g < 200) begin
            @(negedge clk);
            acc = cmd_ready;
            if (!cmd_ready) saw_nr = 1'b1;
            @(posedge clk);
            #1;
            if (acc) begin
                i++;
                cmd_sel = SEL_W'(i);
            end
            g++;
        end
        cmd_valid = 1'b0;
        check_eq("t3_pushed", 64'(i), 64'(8));
        check_eq("t3_ready_dropped", 64'(saw_nr), 64'(1));
        wait_results(base + 8, "t3_count");
        for (int k = 0; k < 8 && base + k < res_log.size(); k++) begin
            check_eq("t3_value", 64'(res_log[base + k]), 64'(t3_exp[k]));
            if (k > 0) begin
                check_eq("t3_gap", 64'(res_cyc[base + k] - res_cyc[base + k - 1]),
                         64'(ALU_LAT + 1));
            end
        end

        // ---------------- 4: backpressure ----------------
        repeat (3) @(posedge clk);
        #1;
        res_ready = 1'b0;
        base = res_log.size();
        e0 = '0;
        for (int j = 0; j < 5; j++) begin
            ra = $urandom;
            rb = $urandom_range(1, 1000);
            rs = SEL_W'($urandom_range(0, 7));
            if (j == 0) e0 = alu_ref(ra, rb, rs);
            push_cmd(ra, rb, rs);
        end
        @(negedge clk);
        check_eq("t4_full", 64'(cmd_ready), 64'(0));
        check_eq("t4_valid", 64'(res_valid), 64'(1));
        check_eq("t4_first", 64'(res_data), 64'(e0));
        repeat (3) @(negedge clk);
        check_eq("t4_first_stable", 64'(res_data), 64'(e0));

        // ---------------- 5: full with simultaneous pop ----------------
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_a = 32'd100;
        cmd_b = 32'd7;
        cmd_sel = 3'd5;
        @(negedge clk);
        check_eq("t5_refused", 64'(cmd_ready), 64'(0));
        @(posedge clk);               // pop edge, push refused
        #1;
        @(negedge clk);
        check_eq("t5_after_pop", 64'(cmd_ready), 64'(1));
        @(posedge clk);               // push accepted, count back to DEPTH
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("t5_refull", 64'(cmd_ready), 64'(0));
        wait_results(base + 6, "t45_count");
        repeat (4) @(posedge clk);
        #1;
        check_eq("t45_idle", 64'(busy), 64'(0));
        check_eq("t45_sb_empty", 64'(exp_q.size()), 64'(0));

        // ---------------- 6: reset mid-WAIT ----------------
        res_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            push_cmd($urandom, $urandom, SEL_W'($urandom_range(0, 6)));
        end
        res_ready = 1'b1;
        @(posedge clk);               // HOLD pops: WAIT with 3 queued
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_valid", 64'(res_valid), 64'(0));
        check_eq("t6_busy", 64'(busy), 64'(0));
        check_eq("t6_ready", 64'(cmd_ready), 64'(1));
        check_eq("t6_alu_a", 64'(alu_a), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (res_valid || busy) seen++;
        end
        check_eq("t6_no_stale", 64'(seen), 64'(0));

        // ---------------- 7: randomized traffic ----------------
        @(posedge clk);
        #1;
        for (int j = 0; j < 400; j++) begin
            cmd_valid = ($urandom_range(0, 99) < 60);
            cmd_a = $urandom;
            cmd_b = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom_range(0, 9)) : $urandom;
            cmd_sel = SEL_W'($urandom_range(0, 7));
            res_ready = ($urandom_range(0, 99) < 65);
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        g = 0;
        while ((exp_q.size() != 0 || busy) && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        check_eq("rand_drained", 64'(exp_q.size()), 64'(0));
        check_eq("rand_idle", 64'(busy), 64'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
